// File: rtl/i2c_xfer_seq.sv
`default_nettype none
// ============================================================================
// i2c_xfer_seq - whole-transfer command sequencer in front of an I2C master.
// Optional relaunch-on-NACK via I2C_XFER_RETRY_EN.                Rev 1.0
// ============================================================================
module i2c_xfer_seq #(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int TIMEOUT_CYC = 100000,
   parameter int MAX_RETRY   = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_rw,
   input  logic [6:0]    cmd_dev,
   input  logic [7:0]    cmd_ptr,
   input  logic [5:0]    cmd_len,
   input  logic          wb_we,
   input  logic [AW-1:0] wb_addr,
   input  logic [7:0]    wb_data,
   input  logic [AW-1:0] rb_addr,
   output logic [7:0]    rb_data,
   output logic          busy,
   output logic          xfer_done,
   output logic          nack_err,
   output logic          tmo_err,
   output logic          len_err,
`ifdef I2C_XFER_RETRY_EN
   output logic [1:0]    retry_cnt,
`endif
   output logic          go,
   output logic          rw,
   output logic [5:0]    N_Byte,
   output logic [6:0]    dev_add,
   output logic [7:0]    R_Pointer,
   output logic [7:0]    dwr,
   input  logic [7:0]    drd,
   input  logic          ready,
   input  logic          done,
   input  logic          ack_e
);

   localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [5:0] LEN_MAX  = 6'(DEPTH);

   if (DEPTH < 1 || DEPTH > 63 || AW > 6 || (2 ** AW) < DEPTH ||
       MAX_RETRY < 0 || MAX_RETRY > 3 || TIMEOUT_CYC < 2) begin : g_param_chk
      $error("i2c_xfer_seq: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_ABORT  = 3'd2,
      S_RUN    = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t        state_q;
   logic [TW-1:0] tcnt_q;
   logic          acnt_q;
   logic [5:0]    bc_q;
   logic          done_q;
   logic          cmd_ready_q, busy_q, xfer_done_q;
   logic          nack_q, tmo_q, len_q;
   logic          go_q, rw_q;
   logic [5:0]    nbyte_q;
   logic [6:0]    dev_q;
   logic [7:0]    ptr_q;
   logic [7:0]    dwr_q;
   logic [7:0]    rb_data_q;
   logic [7:0]    wbuf_q [DEPTH];
   logic [7:0]    rbuf_q [DEPTH];

   logic w_len_ok, w_accept, w_take, w_rise, w_nack, w_retry;

   assign w_len_ok = (cmd_len != 6'd0) && (cmd_len <= LEN_MAX);
   assign w_accept = (state_q == S_IDLE) && cmd_valid && cmd_ready_q && w_len_ok;
   assign w_take   = (state_q == S_RUN) && ready && (bc_q < nbyte_q);
   assign w_rise   = done && !done_q;
   // ack_e is cleared by the master at stop, so fold in the live value
   assign w_nack   = nack_q | ack_e;

`ifdef I2C_XFER_RETRY_EN
   logic [1:0] retry_q;

   assign w_retry   = w_nack && (retry_q < 2'(MAX_RETRY));
   assign retry_cnt = retry_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         retry_q <= 2'd0;
      end else if (w_accept) begin
         retry_q <= 2'd0;
      end else if ((state_q == S_RUN) && w_rise && w_retry) begin
         retry_q <= retry_q + 2'd1;
      end
   end
`else
   assign w_retry = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         tcnt_q      <= '0;
         acnt_q      <= 1'b0;
         bc_q        <= 6'd0;
         done_q      <= 1'b1;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         xfer_done_q <= 1'b0;
         nack_q      <= 1'b0;
         tmo_q       <= 1'b0;
         len_q       <= 1'b0;
         go_q        <= 1'b0;
         rw_q        <= 1'b0;
         nbyte_q     <= 6'd0;
         dev_q       <= 7'd0;
         ptr_q       <= 8'd0;
         dwr_q       <= 8'd0;
      end else begin
         done_q      <= done;
         xfer_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  if (!w_len_ok) begin
                     len_q       <= 1'b1;
                     xfer_done_q <= 1'b1;
                  end else begin
                     rw_q        <= cmd_rw;
                     nbyte_q     <= cmd_len;
                     dev_q       <= cmd_dev;
                     ptr_q       <= cmd_ptr;
                     bc_q        <= 6'd0;
                     nack_q      <= 1'b0;
                     tmo_q       <= 1'b0;
                     len_q       <= 1'b0;
                     busy_q      <= 1'b1;
                     go_q        <= 1'b1;
                     tcnt_q      <= '0;
                     cmd_ready_q <= 1'b0;
                     state_q     <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               if (!done) begin
                  go_q    <= 1'b0;
                  state_q <= S_RUN;
               end else if (tcnt_q == TMO_LAST) begin
                  go_q    <= 1'b0;
                  acnt_q  <= 1'b0;
                  state_q <= S_ABORT;
               end else begin
                  tcnt_q <= tcnt_q + TW'(1);
               end
            end
            S_ABORT: begin
               // the master may have sampled go on the last LAUNCH edge
               acnt_q <= 1'b1;
               if (!done) begin
                  state_q <= S_RUN;
               end else if (acnt_q) begin
                  tmo_q   <= 1'b1;
                  state_q <= S_FINISH;
               end
            end
            S_RUN: begin
               nack_q <= w_nack;
               if (w_take) begin
                  if (!rw_q) begin
                     dwr_q <= wbuf_q[bc_q[AW-1:0]];
                  end
                  bc_q <= bc_q + 6'd1;
               end
               if (w_rise) begin
                  if (w_retry) begin
                     nack_q  <= 1'b0;
                     bc_q    <= 6'd0;
                     tcnt_q  <= '0;
                     go_q    <= 1'b1;
                     state_q <= S_LAUNCH;
                  end else begin
                     state_q <= S_FINISH;
                  end
               end
            end
            S_FINISH: begin
               xfer_done_q <= 1'b1;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wb_we) begin
         wbuf_q[wb_addr] <= wb_data;
      end
      if (w_take && rw_q) begin
         rbuf_q[bc_q[AW-1:0]] <= drd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rb_data_q <= 8'd0;
      end else begin
         rb_data_q <= rbuf_q[rb_addr];
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign xfer_done = xfer_done_q;
   assign nack_err  = nack_q;
   assign tmo_err   = tmo_q;
   assign len_err   = len_q;
   assign go        = go_q;
   assign rw        = rw_q;
   assign N_Byte    = nbyte_q;
   assign dev_add   = dev_q;
   assign R_Pointer = ptr_q;
   assign dwr       = dwr_q;
   assign rb_data   = rb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_xfer_seq.sv
`default_nettype none
// tb_i2c_xfer_seq - transfer-level vector table driven through a small I2C
// master model, plus hand sequences for reset and same-cycle buffer corners.
module tb_i2c_xfer_seq;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int TMO   = 50;
`ifdef I2C_XFER_RETRY_EN
   localparam int NLAUNCH_NACK = 4;
`else
   localparam int NLAUNCH_NACK = 1;
`endif

   logic          clk = 1'b0;
   logic          reset, cmd_valid, cmd_ready, cmd_rw;
   logic [6:0]    cmd_dev;
   logic [7:0]    cmd_ptr;
   logic [5:0]    cmd_len;
   logic          wb_we;
   logic [AW-1:0] wb_addr, rb_addr;
   logic [7:0]    wb_data, rb_data;
   logic          busy, xfer_done, nack_err, tmo_err, len_err;
   logic          go, rw, ready, done, ack_e;
   logic [5:0]    N_Byte;
   logic [6:0]    dev_add;
   logic [7:0]    R_Pointer, dwr, drd;
`ifdef I2C_XFER_RETRY_EN
   logic [1:0]    retry_cnt;
`endif

   always #5 clk = ~clk;

   i2c_xfer_seq #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYC(TMO), .MAX_RETRY(3)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_dev(cmd_dev), .cmd_ptr(cmd_ptr), .cmd_len(cmd_len),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .rb_addr(rb_addr), .rb_data(rb_data),
      .busy(busy), .xfer_done(xfer_done), .nack_err(nack_err),
      .tmo_err(tmo_err), .len_err(len_err),
`ifdef I2C_XFER_RETRY_EN
      .retry_cnt(retry_cnt),
`endif
      .go(go), .rw(rw), .N_Byte(N_Byte), .dev_add(dev_add),
      .R_Pointer(R_Pointer), .dwr(dwr), .drd(drd),
      .ready(ready), .done(done), .ack_e(ack_e)
   );

   typedef struct packed {
      logic       rw;
      logic [6:0] dev;
      logic [7:0] ptr;
      logic [5:0] len;
      logic       nack;        // master model: slave NACKs
      logic       stuck;       // master model: never leaves idle
      logic       rdy_at_done; // last ready coincides with done rising
      logic       e_len;
      logic       e_nack;
      logic       e_tmo;
   } vec_t;

   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] wmodel [DEPTH];
   logic [7:0] rmodel [DEPTH];
   logic [7:0] rsrc   [DEPTH];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] p, input logic [5:0] l);
      chk("cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_rw = r; cmd_dev = d; cmd_ptr = p; cmd_len = l;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic launch(input string t);
      int cnt = 0;
      while (go !== 1'b1 && cnt < 20) begin step(); cnt++; end
      chk({t, "_go"}, go, 1);
      done = 1'b0;
      step();
      chk({t, "_go_drop"}, go, 0);
   endtask

   task automatic pulse_ready(input logic [7:0] d, input bit with_done);
      step(); step();
      ready = 1'b1; drd = d;
      if (with_done) done = 1'b1;
      step();
      ready = 1'b0;
   endtask

   task automatic wait_done(input string t, input logic e_nack, input logic e_tmo);
      int cnt = 0;
      while (xfer_done !== 1'b1 && cnt < 40) begin step(); cnt++; end
      chk({t, "_done"}, xfer_done, 1);
      chk({t, "_nack"}, nack_err, e_nack);
      chk({t, "_tmo"}, tmo_err, e_tmo);
      chk({t, "_busy"}, busy, 0);
      step();
      chk({t, "_pulse"}, xfer_done, 0);
   endtask

   task automatic run_vec(input int k, input vec_t v);
      int    cnt;
      string t;
      t = $sformatf("v%0d", k);
      issue(v.rw, v.dev, v.ptr, v.len);
      if (v.e_len) begin
         chk({t, "_len_err"}, len_err, 1);
         chk({t, "_done"}, xfer_done, 1);
         chk({t, "_go"}, go, 0);
         step();
         chk({t, "_pulse"}, xfer_done, 0);
         chk({t, "_go_after"}, go, 0);
         return;
      end
      chk({t, "_busy"}, busy, 1);
      chk({t, "_fields"}, {rw, N_Byte, dev_add, R_Pointer}, {v.rw, v.len, v.dev, v.ptr});
      if (v.stuck) begin
         cnt = 1;
         while (go === 1'b1 && cnt < 4 * TMO) begin
            step();
            if (go === 1'b1) cnt++;
         end
         chk({t, "_go_cycles"}, cnt, TMO);
         cnt = 0;
         while (xfer_done !== 1'b1 && cnt < 20) begin step(); cnt++; end
         chk({t, "_tmo_lat"}, cnt, 3);
         wait_done(t, v.e_nack, v.e_tmo);
         return;
      end
      if (v.nack) begin
         for (int n = 0; n < NLAUNCH_NACK; n++) begin
            launch(t);
            ack_e = 1'b1; step(); step();
            ack_e = 1'b0; step();
            done = 1'b1; step();
         end
         wait_done(t, v.e_nack, v.e_tmo);
`ifdef I2C_XFER_RETRY_EN
         chk({t, "_retry_cnt"}, retry_cnt, 3);
`endif
         return;
      end
      launch(t);
      for (int i = 0; i < int'(v.len); i++) begin
         pulse_ready(rsrc[i], v.rdy_at_done && (i == int'(v.len) - 1));
         if (!v.rw) chk($sformatf("%s_dwr%0d", t, i), dwr, wmodel[i]);
      end
      if (!v.rdy_at_done) begin
         if (!v.rw) begin
            pulse_ready(8'h00, 1'b0);
            chk({t, "_dwr_extra"}, dwr, wmodel[int'(v.len) - 1]);
         end
         done = 1'b1; step();
      end
      wait_done(t, v.e_nack, v.e_tmo);
      if (v.rw) begin
         for (int i = 0; i < int'(v.len); i++) begin
            rmodel[i] = rsrc[i];
            rb_addr = AW'(i);
            step();
            chk($sformatf("%s_rb%0d", t, i), rb_data, rsrc[i]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      vec_t tbl [8];
      logic [7:0] d;
      tbl[0] = '{1'b0, 7'h48, 8'h01, 6'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 7'h48, 8'h02, 6'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 7'h48, 8'h01, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 7'h48, 8'h01, 6'd17, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 7'h21, 8'h00, 6'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 7'h48, 8'h01, 6'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 7'h5A, 8'h80, 6'd16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 7'h3C, 8'h7F, 6'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = '0; cmd_ptr = '0; cmd_len = '0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0; rb_addr = '0;
      done = 1'b1; ready = 1'b0; ack_e = 1'b0; drd = '0;
      step(); step(); step();
      chk("rst_go", go, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_xfer_done", xfer_done, 0);
      chk("rst_errs", {nack_err, tmo_err, len_err}, 0);
      chk("rst_dwr", dwr, 0);
      chk("rst_rb_data", rb_data, 0);
      reset = 1'b0;
      step();
      chk("rst_cmd_ready_up", cmd_ready, 1);

      for (int i = 0; i < DEPTH; i++) begin
         d = (i < 3) ? 8'(8'h11 * (i + 1)) : 8'(8'h40 + i);
         wb_we = 1'b1; wb_addr = AW'(i); wb_data = d;
         step();
         wmodel[i] = d;
      end
      wb_we = 1'b0;

      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < DEPTH; i++) rsrc[i] = 8'(8'h90 + i * 5 + k * 11);
         if (k == 1) begin rsrc[0] = 8'hA5; rsrc[1] = 8'h5A; end
         run_vec(k, tbl[k]);
      end

      // reset in the middle of a write, then a clean transfer
      issue(1'b0, 7'h48, 8'h01, 6'd3);
      launch("rst_mid");
      pulse_ready(8'h00, 1'b0);
      chk("rst_mid_dwr0", dwr, wmodel[0]);
      reset = 1'b1; done = 1'b1;
      step();
      chk("rst_mid_go", go, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_cmd_ready", cmd_ready, 0);
      reset = 1'b0;
      step();
      chk("rst_mid_cmd_ready_up", cmd_ready, 1);
      run_vec(0, tbl[0]);

      // buffer write to the entry being fetched for dwr in the same cycle
      issue(1'b0, 7'h48, 8'h01, 6'd2);
      launch("wbc");
      step();
      ready = 1'b1; wb_we = 1'b1; wb_addr = '0; wb_data = 8'hEE;
      step();
      ready = 1'b0; wb_we = 1'b0;
      chk("wbc_dwr_old", dwr, wmodel[0]);
      wmodel[0] = 8'hEE;
      pulse_ready(8'h00, 1'b0);
      chk("wbc_dwr1", dwr, wmodel[1]);
      done = 1'b1; step();
      wait_done("wbc", 1'b0, 1'b0);
      run_vec(0, tbl[0]);

      // read-buffer read of the entry being captured in the same cycle
      issue(1'b1, 7'h50, 8'h00, 6'd1);
      launch("rbc");
      rb_addr = '0;
      step();
      chk("rbc_pre", rb_data, rmodel[0]);
      ready = 1'b1; drd = 8'h3C;
      step();
      ready = 1'b0;
      chk("rbc_old", rb_data, rmodel[0]);
      step();
      chk("rbc_new", rb_data, 8'h3C);
      rmodel[0] = 8'h3C;
      done = 1'b1; step();
      wait_done("rbc", 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
